branch_resolve: RTL and testbench

Parametrised, buffered branch-resolution unit. It accepts one branch micro-op per cycle from issue (tagged with ROB uid, target value, condition operand, condition mode). It evaluates the condition over a configurable operand width and queues results in a DEPTH-entry FIFO. Results drain to writeback/ROB under a valid/ready handshake. A flush input drops all in-flight results on misprediction recovery.

---
 rtl/branch_resolve.sv | 146 ++++++++++++++
 tb/tb_branch_resolve.sv | 282 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/branch_resolve.sv
// Branch-resolution unit: evaluates a branch condition per accepted op and queues {uid, target, taken}
// in a small FIFO toward writeback. Optional macro BRANCH_STATS_EN adds pop-time taken/total counters.
`ifndef ROB_QUEUE_BITS
`define ROB_QUEUE_BITS 5
`endif

module branch_resolve #(
  parameter int WIDTH    = 16,
  parameter int UID_BITS = `ROB_QUEUE_BITS,
  parameter int DEPTH    = 4
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [UID_BITS-1:0] in_uid,
  input  logic [WIDTH-1:0]    in_target,
  input  logic [WIDTH-1:0]    in_cond,
  input  logic [2:0]          in_mode,
  input  logic                flush,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [UID_BITS-1:0] out_uid,
  output logic [WIDTH-1:0]    out_result,
  output logic [WIDTH+1:0]    out_loc
`ifdef BRANCH_STATS_EN
  ,
  output logic [31:0]         stat_taken,
  output logic [31:0]         stat_total
`endif
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam logic [CNT_W-1:0] FULL_COUNT = CNT_W'(DEPTH);

  typedef enum logic [2:0] {
    MODE_EQZ    = 3'd0,
    MODE_NEZ    = 3'd1,
    MODE_LTZ    = 3'd2,
    MODE_GEZ    = 3'd3,
    MODE_GTZ    = 3'd4,
    MODE_LEZ    = 3'd5,
    MODE_ALWAYS = 3'd6,
    MODE_NEVER  = 3'd7
  } mode_e;

  logic [UID_BITS-1:0] uid_mem    [DEPTH];
  logic [WIDTH-1:0]    target_mem [DEPTH];
  logic                taken_mem  [DEPTH];

  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic [CNT_W-1:0] count;

  logic cond_zero;
  logic cond_neg;
  logic taken;
  logic push;
  logic pop;

  // Sign is taken from the operand MSB only; the operand is never width-extended.
  assign cond_zero = (in_cond == '0);
  assign cond_neg  = in_cond[WIDTH-1];

  always_comb begin
    taken = 1'b0;
    unique case (mode_e'(in_mode))
      MODE_EQZ:    taken = cond_zero;
      MODE_NEZ:    taken = !cond_zero;
      MODE_LTZ:    taken = cond_neg;
      MODE_GEZ:    taken = !cond_neg;
      MODE_GTZ:    taken = !cond_neg && !cond_zero;
      MODE_LEZ:    taken = cond_neg || cond_zero;
      MODE_ALWAYS: taken = 1'b1;
      MODE_NEVER:  taken = 1'b0;
      default:     taken = 1'b0;
    endcase
  end

  // A flush wins over any handshake in the same cycle: the accepted op and any pop are dropped.
  assign in_ready  = (count != FULL_COUNT);
  assign out_valid = (count != '0);
  assign push      = in_valid && in_ready && !flush;
  assign pop       = out_valid && out_ready && !flush;

  always_ff @(posedge clk) begin
    if (push) begin
      uid_mem[wr_ptr]    <= in_uid;
      target_mem[wr_ptr] <= in_target;
      taken_mem[wr_ptr]  <= taken;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) begin
        wr_ptr <= wr_ptr + PTR_W'(1);
      end
      if (pop) begin
        rd_ptr <= rd_ptr + PTR_W'(1);
      end
      if (push && !pop) begin
        count <= count + CNT_W'(1);
      end else if (pop && !push) begin
        count <= count - CNT_W'(1);
      end
    end
  end

  // Head fields are forced to zero while empty so reset/flush never expose stale storage.
  always_comb begin
    out_uid    = '0;
    out_result = '0;
    out_loc    = '0;
    if (out_valid) begin
      out_uid    = uid_mem[rd_ptr];
      out_result = target_mem[rd_ptr];
      out_loc    = {1'b1, {WIDTH{1'b0}}, taken_mem[rd_ptr]};
    end
  end

`ifdef BRANCH_STATS_EN
  // Counted at pop so flushed (wrong-path) results never reach the statistics.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stat_total <= '0;
      stat_taken <= '0;
    end else if (pop) begin
      stat_total <= stat_total + 32'd1;
      if (taken_mem[rd_ptr]) begin
        stat_taken <= stat_taken + 32'd1;
      end
    end
  end
`endif

endmodule

// File: tb/tb_branch_resolve.sv
// Self-checking bench for branch_resolve: a negedge monitor keeps a scoreboard queue of expected
// results and compares every head, handshake and (with BRANCH_STATS_EN) counter value.
module tb_branch_resolve;

  localparam int WIDTH    = 16;
  localparam int UID_BITS = 6;
  localparam int DEPTH    = 4;

  typedef struct packed {
    logic [UID_BITS-1:0] uid;
    logic [WIDTH-1:0]    target;
    logic                taken;
  } exp_t;

  logic                clk;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [UID_BITS-1:0] in_uid;
  logic [WIDTH-1:0]    in_target;
  logic [WIDTH-1:0]    in_cond;
  logic [2:0]          in_mode;
  logic                flush;
  logic                out_valid;
  logic                out_ready;
  logic [UID_BITS-1:0] out_uid;
  logic [WIDTH-1:0]    out_result;
  logic [WIDTH+1:0]    out_loc;
`ifdef BRANCH_STATS_EN
  logic [31:0]         stat_taken;
  logic [31:0]         stat_total;
  int unsigned         model_total;
  int unsigned         model_taken_cnt;
`endif

  exp_t q[$];
  exp_t head;
  int   n_checks;
  int   n_fail;
  logic model_ready;
  logic model_valid;

  branch_resolve #(
    .WIDTH(WIDTH),
    .UID_BITS(UID_BITS),
    .DEPTH(DEPTH)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .in_uid(in_uid),
    .in_target(in_target),
    .in_cond(in_cond),
    .in_mode(in_mode),
    .flush(flush),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_uid(out_uid),
    .out_result(out_result),
    .out_loc(out_loc)
`ifdef BRANCH_STATS_EN
    ,
    .stat_taken(stat_taken),
    .stat_total(stat_total)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Reference condition evaluation using a signed integer view of the operand.
  function automatic logic model_taken(input logic [WIDTH-1:0] c, input logic [2:0] m);
    int v;
    v = int'($signed(c));
    case (m)
      3'd0:    return v == 0;
      3'd1:    return v != 0;
      3'd2:    return v < 0;
      3'd3:    return v >= 0;
      3'd4:    return v > 0;
      3'd5:    return v <= 0;
      3'd6:    return 1'b1;
      default: return 1'b0;
    endcase
  endfunction

  // Offer one op and hold it until the DUT accepts it, within a cycle budget.
  task automatic applyStimulus(input logic [UID_BITS-1:0] uid, input logic [WIDTH-1:0] target,
                               input logic [WIDTH-1:0] cond, input logic [2:0] mode);
    logic accepted;
    accepted  = 1'b0;
    in_valid  = 1'b1;
    in_uid    = uid;
    in_target = target;
    in_cond   = cond;
    in_mode   = mode;
    for (int i = 0; i < 50 && !accepted; i++) begin
      @(negedge clk);
      if (in_ready) accepted = 1'b1;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("accept_timeout", 64'(accepted), 64'd1);
  endtask

  // Monitor: compare against the scoreboard, then advance it for the coming edge.
  always @(negedge clk) begin
    if (!rst) begin
      model_ready = (q.size() != DEPTH);
      model_valid = (q.size() != 0);
      checkOutput("in_ready", 64'(in_ready), 64'(model_ready));
      checkOutput("out_valid", 64'(out_valid), 64'(model_valid));
      if (model_valid) begin
        head = q[0];
        checkOutput("out_uid", 64'(out_uid), 64'(head.uid));
        checkOutput("out_result", 64'(out_result), 64'(head.target));
        checkOutput("out_loc", 64'(out_loc), 64'({1'b1, {WIDTH{1'b0}}, head.taken}));
      end
`ifdef BRANCH_STATS_EN
      checkOutput("stat_total", 64'(stat_total), 64'(model_total));
      checkOutput("stat_taken", 64'(stat_taken), 64'(model_taken_cnt));
`endif
      if (flush) begin
        q.delete();
      end else begin
        if (model_valid && out_ready) begin
`ifdef BRANCH_STATS_EN
          model_total++;
          if (q[0].taken) model_taken_cnt++;
`endif
          void'(q.pop_front());
        end
        if (model_ready && in_valid) begin
          q.push_back('{uid: in_uid, target: in_target, taken: model_taken(in_cond, in_mode)});
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [WIDTH-1:0] conds [4];
    conds = '{16'h0000, 16'h0001, 16'h8000, 16'hFFFF};
    n_checks  = 0;
    n_fail    = 0;
    rst       = 1'b1;
    in_valid  = 1'b0;
    in_uid    = '0;
    in_target = '0;
    in_cond   = '0;
    in_mode   = '0;
    flush     = 1'b0;
    out_ready = 1'b0;
`ifdef BRANCH_STATS_EN
    model_total     = 0;
    model_taken_cnt = 0;
`endif
    #2;
    checkOutput("rst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("rst_out_uid", 64'(out_uid), 64'd0);
    checkOutput("rst_out_result", 64'(out_result), 64'd0);
    checkOutput("rst_out_loc", 64'(out_loc), 64'd0);
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Mode sweep over the four corner operands.
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      for (int m = 0; m < 8; m++) begin
        applyStimulus(UID_BITS'(c * 8 + m), WIDTH'($urandom), conds[c], 3'(m));
      end
    end
    repeat (3) @(posedge clk);
    #1;

    // Backpressure: fill the FIFO, hold a fifth op, then release the consumer.
    out_ready = 1'b0;
    fork
      begin
        for (int u = 1; u <= 5; u++) begin
          applyStimulus(UID_BITS'(u), WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)));
        end
      end
      begin
        repeat (8) @(posedge clk);
        #1 out_ready = 1'b1;
      end
    join
    repeat (8) @(posedge clk);
    #1;

    // Wrap-around: continuous push/pop through several pointer wraps.
    for (int u = 0; u < 10; u++) begin
      applyStimulus(UID_BITS'(32 + u), WIDTH'($urandom), WIDTH'($urandom), 3'($urandom_range(0, 7)));
    end
    repeat (3) @(posedge clk);
    #1;

    // Flush with three entries queued and a same-cycle offer that must be dropped.
    out_ready = 1'b0;
    for (int u = 11; u <= 13; u++) begin
      applyStimulus(UID_BITS'(u), WIDTH'($urandom), 16'h0000, 3'd0);
    end
    flush     = 1'b1;
    in_valid  = 1'b1;
    in_uid    = UID_BITS'(9);
    in_target = 16'h0099;
    in_mode   = 3'd6;
    @(posedge clk);
    #1;
    flush    = 1'b0;
    in_valid = 1'b0;
    checkOutput("flush_out_valid", 64'(out_valid), 64'd0);
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;

    // Asynchronous reset between edges with two entries queued.
    out_ready = 1'b0;
    applyStimulus(UID_BITS'(20), 16'h1234, 16'h0001, 3'd6);
    applyStimulus(UID_BITS'(21), 16'h5678, 16'h0001, 3'd6);
    #2 rst = 1'b1;
    #1;
    checkOutput("arst_out_valid", 64'(out_valid), 64'd0);
    checkOutput("arst_in_ready", 64'(in_ready), 64'd1);
    checkOutput("arst_out_uid", 64'(out_uid), 64'd0);
    checkOutput("arst_out_result", 64'(out_result), 64'd0);
    checkOutput("arst_out_loc", 64'(out_loc), 64'd0);
    q.delete();
`ifdef BRANCH_STATS_EN
    checkOutput("arst_stat_total", 64'(stat_total), 64'd0);
    model_total     = 0;
    model_taken_cnt = 0;
`endif
    #1 rst = 1'b0;
    @(posedge clk);
    #1;

`ifdef BRANCH_STATS_EN
    // Statistics: five pops (three taken), then two flushed entries that must not count.
    out_ready = 1'b1;
    for (int u = 0; u < 5; u++) begin
      applyStimulus(UID_BITS'(40 + u), WIDTH'($urandom), 16'h0000, (u < 3) ? 3'd6 : 3'd7);
    end
    repeat (3) @(posedge clk);
    #1 out_ready = 1'b0;
    applyStimulus(UID_BITS'(50), 16'h0050, 16'h0000, 3'd6);
    applyStimulus(UID_BITS'(51), 16'h0051, 16'h0000, 3'd6);
    flush = 1'b1;
    @(posedge clk);
    #1 flush = 1'b0;
    @(posedge clk);
    #1;
    checkOutput("stats_total", 64'(stat_total), 64'd5);
    checkOutput("stats_taken", 64'(stat_taken), 64'd3);
`endif

    out_ready = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    checkOutput("drain_empty", 64'(q.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
